// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CHECK,
    DONE,
    ERROR
  } loader_state_t;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/instruction_loader_byte_assembler.sv
// Byte assembler: packs four bytes MSB-first into a 32-bit word.
// next_word/last_byte give the word being completed in the same cycle as
// its final byte; word_valid is a registered pulse one cycle later, raised
// only when emit was high as the final byte arrived.
module byte_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic        emit,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic [31:0] next_word,
  output logic        last_byte,
  output logic        word_valid
);

  logic [1:0]  count;
  logic [31:0] shift;

  assign next_word = {shift[23:0], byte_data};
  assign last_byte = byte_valid && (count == 2'(WORD_BYTES - 1));
  assign word      = shift;

  // Shift register, byte position counter and the word-complete pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift      <= '0;
      count      <= '0;
      word_valid <= 1'b0;
    end else if (clear) begin
      shift      <= '0;
      count      <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= last_byte && emit;
      if (byte_valid) begin
        shift <= next_word;
        count <= count + 2'd1;
      end
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// Instruction loader: frames a UART byte stream (32-bit big-endian word
// count, then big-endian words) into instruction memory writes.
// Optional macro LOADER_CHECKSUM_EN adds a trailing XOR checksum byte that
// must match the XOR of all payload bytes.
module instruction_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        write_enable,
  output logic [31:0] byte_address,
  output logic [31:0] write_data,
  output logic        loading,
  output logic        done,
  output logic        error
);

  localparam logic [31:0] MAX_WORDS = 32'(MEM_BYTES / WORD_BYTES);

  loader_state_t state, next_state;

  logic        accept;
  logic        word_valid;
  logic        last_byte;
  logic        last_word;
  logic [31:0] word;
  logic [31:0] next_word;
  logic [31:0] length;
  logic [15:0] word_count;

  // start always wins over a byte arriving in the same cycle.
  assign accept    = rx_valid && !start && ((state == LEN) || (state == DATA));
  assign last_word = ({16'd0, word_count} + 32'd1) == length;

  byte_assembler assembler (
    .clk        (clk),
    .rst        (rst),
    .clear      (start),
    .byte_valid (accept),
    .emit       (state == DATA),
    .byte_data  (rx_data),
    .word       (word),
    .next_word  (next_word),
    .last_byte  (last_byte),
    .word_valid (word_valid)
  );

  assign write_enable = (state == DATA) && word_valid;
  assign write_data   = word;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] checksum;
  logic       payload_byte;

  // A byte arriving during the final strobe is the checksum, not payload.
  assign payload_byte = accept && (state == DATA) && !(word_valid && last_word);

  // Running XOR over payload bytes only; the header is excluded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum <= '0;
    end else if (start) begin
      checksum <= '0;
    end else if (payload_byte) begin
      checksum <= checksum ^ rx_data;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; start restarts the load from any state.
  always_comb begin
    next_state = state;
    if (start) begin
      next_state = LEN;
    end else begin
      case (state)
        LEN: begin
          if (last_byte) begin
            if (next_word == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
              next_state = CHECK;
`else
              next_state = DONE;
`endif
            end else if (next_word > MAX_WORDS) begin
              next_state = ERROR;
            end else begin
              next_state = DATA;
            end
          end
        end
        DATA: begin
          if (word_valid && last_word) begin
`ifdef LOADER_CHECKSUM_EN
            if (rx_valid) begin
              next_state = (rx_data == checksum) ? DONE : ERROR;
            end else begin
              next_state = CHECK;
            end
`else
            next_state = DONE;
`endif
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK: begin
          if (rx_valid) begin
            next_state = (rx_data == checksum) ? DONE : ERROR;
          end
        end
`endif
        default: next_state = state;
      endcase
    end
  end

  // Status outputs decoded from the current state.
  always_comb begin
    loading = (state == LEN) || (state == DATA) || (state == CHECK);
    done    = (state == DONE);
    error   = (state == ERROR);
  end

  // Write address: advances by one word in the cycle after each strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_address <= BASE_ADDR;
    end else if (start) begin
      byte_address <= BASE_ADDR;
    end else if (write_enable) begin
      byte_address <= byte_address + 32'd4;
    end
  end

  // Count of words written so far and the word count from the header.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_count <= '0;
      length     <= '0;
    end else if (start) begin
      word_count <= '0;
      length     <= '0;
    end else begin
      if (write_enable) begin
        word_count <= word_count + 16'd1;
      end
      if ((state == LEN) && last_byte) begin
        length <= next_word;
      end
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Testbench for instruction_loader: directed scenarios plus randomized
// images checked against a byte-stream reference model.
// Honours LOADER_CHECKSUM_EN the same way as the design.
module tb_instruction_loader;

  localparam logic [31:0] BASE  = 32'h0;
  localparam int          MAX_N = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        write_enable;
  logic [31:0] byte_address;
  logic [31:0] write_data;
  logic        loading;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  logic [7:0]  stim[$];
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic        exp_done;
  logic        exp_error;

  instruction_loader #(.BASE_ADDR(BASE), .MEM_BYTES(1024)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .write_enable (write_enable),
    .byte_address (byte_address),
    .write_data   (write_data),
    .loading      (loading),
    .done         (done),
    .error        (error)
  );

  always #5 clk = ~clk;

  // Cycle counter used to measure strobe spacing.
  always @(posedge clk) cycle <= cycle + 1;

  // Capture every write strobe away from the active edge.
  always @(negedge clk) begin
    if (write_enable === 1'b1) begin
      wr_addr.push_back(byte_address);
      wr_data.push_back(write_data);
      wr_cyc.push_back(cycle);
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic clear_writes();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_stim(input int max_gap);
    for (int i = 0; i < stim.size(); i++) begin
      rx_data  = stim[i];
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) @(negedge clk);
    end
  endtask

  // Reference model: expected writes and final status from the byte stream.
  task automatic model_load();
    logic [31:0] n;
    logic [7:0]  x;
    exp_addr.delete();
    exp_data.delete();
    exp_done  = 1'b0;
    exp_error = 1'b0;
    x = 8'h00;
    n = {stim[0], stim[1], stim[2], stim[3]};
    if (n > MAX_N) begin
      exp_error = 1'b1;
    end else begin
      for (int k = 0; k < int'(n); k++) begin
        exp_addr.push_back(BASE + 32'(4 * k));
        exp_data.push_back({stim[4+4*k], stim[5+4*k], stim[6+4*k], stim[7+4*k]});
        x = x ^ stim[4+4*k] ^ stim[5+4*k] ^ stim[6+4*k] ^ stim[7+4*k];
      end
`ifdef LOADER_CHECKSUM_EN
      if (stim[4+4*int'(n)] == x) exp_done = 1'b1;
      else exp_error = 1'b1;
`else
      exp_done = 1'b1;
`endif
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if ({write_enable, loading, done, error} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b expected 0000", {write_enable, loading, done, error});
    end
    checks++;
    if (byte_address !== BASE || write_data !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_regs: got addr %h data %h expected %h 0", byte_address, write_data, BASE);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    clear_writes();
    stim = '{8'h00, 8'h00, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
             8'h00, 8'h00, 8'h00, 8'h13};
`ifdef LOADER_CHECKSUM_EN
    stim.push_back(8'h31);
`endif
    pulse_start();
    checks++;
    if (loading !== 1'b1) begin
      errors++;
      $display("[TB] FAIL nominal_loading: got %b expected 1", loading);
    end
    send_stim(2);
    repeat (3) @(negedge clk);
    checks++;
    if (wr_data.size() !== 2) begin
      errors++;
      $display("[TB] FAIL nominal_count: got %0d expected 2", wr_data.size());
    end else begin
      checks++;
      if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'hDEADBEEF) begin
        errors++;
        $display("[TB] FAIL nominal_w0: got %h/%h expected 0/deadbeef", wr_addr[0], wr_data[0]);
      end
      checks++;
      if (wr_addr[1] !== 32'h4 || wr_data[1] !== 32'h00000013) begin
        errors++;
        $display("[TB] FAIL nominal_w1: got %h/%h expected 4/00000013", wr_addr[1], wr_data[1]);
      end
    end
    checks++;
    if ({done, loading, error} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL nominal_status: got %b expected 100", {done, loading, error});
    end
  endtask

  task automatic test_zero_length();
    clear_writes();
    stim = '{8'h00, 8'h00, 8'h00, 8'h00};
    pulse_start();
    send_stim(0);
`ifdef LOADER_CHECKSUM_EN
    checks++;
    if ({loading, done} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL zero_check_wait: got %b expected 10", {loading, done});
    end
    stim = '{8'h00};
    send_stim(0);
`endif
    checks++;
    if ({done, error, loading} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL zero_done: got %b expected 100", {done, error, loading});
    end
    repeat (2) @(negedge clk);
    checks++;
    if (wr_data.size() !== 0) begin
      errors++;
      $display("[TB] FAIL zero_writes: got %0d expected 0", wr_data.size());
    end
  endtask

  task automatic test_oversize();
    clear_writes();
    stim = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    pulse_start();
    send_stim(1);
    repeat (3) @(negedge clk);
    checks++;
    if ({error, done, loading} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL oversize_status: got %b expected 100", {error, done, loading});
    end
    checks++;
    if (wr_data.size() !== 0) begin
      errors++;
      $display("[TB] FAIL oversize_writes: got %0d expected 0", wr_data.size());
    end
  endtask

  task automatic test_back_to_back();
    clear_writes();
    stim = '{8'h00, 8'h00, 8'h00, 8'h02};
    for (int i = 0; i < 8; i++) stim.push_back(8'($urandom_range(255, 0)));
`ifdef LOADER_CHECKSUM_EN
    stim.push_back(stim[4] ^ stim[5] ^ stim[6] ^ stim[7] ^ stim[8] ^ stim[9] ^ stim[10] ^ stim[11]);
`endif
    pulse_start();
    send_stim(0);
    repeat (3) @(negedge clk);
    checks++;
    if (wr_data.size() !== 2) begin
      errors++;
      $display("[TB] FAIL b2b_count: got %0d expected 2", wr_data.size());
    end else begin
      checks++;
      if (wr_cyc[1] - wr_cyc[0] !== 4) begin
        errors++;
        $display("[TB] FAIL b2b_spacing: got %0d expected 4", wr_cyc[1] - wr_cyc[0]);
      end
      checks++;
      if (wr_data[0] !== {stim[4], stim[5], stim[6], stim[7]} ||
          wr_data[1] !== {stim[8], stim[9], stim[10], stim[11]}) begin
        errors++;
        $display("[TB] FAIL b2b_data: got %h %h expected %h %h", wr_data[0], wr_data[1],
                 {stim[4], stim[5], stim[6], stim[7]}, {stim[8], stim[9], stim[10], stim[11]});
      end
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_done: got %b expected 1", done);
    end
  endtask

  task automatic test_reset_mid_word();
    clear_writes();
    stim = '{8'h00, 8'h00, 8'h00, 8'h01, 8'hAB, 8'hCD};
    pulse_start();
    send_stim(0);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({write_enable, loading, done, error} !== 4'b0000 || byte_address !== BASE) begin
      errors++;
      $display("[TB] FAIL midreset_state: got %b addr %h expected 0000 addr %h",
               {write_enable, loading, done, error}, byte_address, BASE);
    end
    rst = 1'b0;
    @(negedge clk);
    stim = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
`ifdef LOADER_CHECKSUM_EN
    stim.push_back(8'h08);
`endif
    pulse_start();
    send_stim(1);
    repeat (3) @(negedge clk);
    checks++;
    if (wr_data.size() !== 1) begin
      errors++;
      $display("[TB] FAIL midreset_count: got %0d expected 1", wr_data.size());
    end else begin
      checks++;
      if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h12345678) begin
        errors++;
        $display("[TB] FAIL midreset_word: got %h/%h expected 0/12345678", wr_addr[0], wr_data[0]);
      end
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_done: got %b expected 1", done);
    end
  endtask

  task automatic test_restart();
    clear_writes();
    stim = '{8'h00, 8'h00, 8'h01, 8'h01};
    pulse_start();
    send_stim(0);
    @(negedge clk);
    pulse_start();
    checks++;
    if ({error, loading} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL restart_clear: got %b expected 01", {error, loading});
    end
    stim = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33};
    send_stim(0);
    start = 1'b1; rx_valid = 1'b1; rx_data = 8'hAA;
    @(negedge clk);
    start = 1'b0; rx_valid = 1'b0;
    stim = '{8'h00, 8'h00, 8'h00, 8'h01, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
`ifdef LOADER_CHECKSUM_EN
    stim.push_back(8'h04);
`endif
    send_stim(0);
    repeat (3) @(negedge clk);
    checks++;
    if (wr_data.size() !== 1 || wr_data[0] !== 32'hA1B2C3D4 || wr_addr[0] !== 32'h0) begin
      errors++;
      $display("[TB] FAIL restart_write: got %0d writes first %h expected 1 write a1b2c3d4 at 0",
               wr_data.size(), (wr_data.size() > 0) ? wr_data[0] : 32'h0);
    end
    checks++;
    if ({done, error} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL restart_done: got %b expected 10", {done, error});
    end
  endtask

  task automatic test_random();
    logic [31:0] n;
    logic [7:0]  x;
    int          sel;
    for (int it = 0; it < 20; it++) begin
      clear_writes();
      sel = $urandom_range(9, 0);
      n = (sel == 0) ? 32'd0 : (sel == 1) ? 32'(257 + $urandom_range(50, 0)) : 32'($urandom_range(6, 1));
      stim = '{n[31:24], n[23:16], n[15:8], n[7:0]};
      x = 8'h00;
      if (n <= MAX_N) begin
        for (int i = 0; i < 4 * int'(n); i++) begin
          stim.push_back(8'($urandom_range(255, 0)));
          x = x ^ stim[stim.size() - 1];
        end
`ifdef LOADER_CHECKSUM_EN
        stim.push_back(($urandom_range(1, 0) == 1) ? x : (x ^ 8'($urandom_range(255, 1))));
`endif
      end
      stim.push_back(8'($urandom_range(255, 0)));
      stim.push_back(8'($urandom_range(255, 0)));
      model_load();
      pulse_start();
      send_stim(2);
      repeat (3) @(negedge clk);
      checks++;
      if (wr_data.size() !== exp_data.size()) begin
        errors++;
        $display("[TB] FAIL random%0d_count: got %0d expected %0d", it, wr_data.size(), exp_data.size());
      end
      for (int i = 0; i < wr_data.size() && i < exp_data.size(); i++) begin
        checks++;
        if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
          errors++;
          $display("[TB] FAIL random%0d_w%0d: got %h/%h expected %h/%h", it, i,
                   wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
        end
      end
      checks++;
      if ({done, error, loading} !== {exp_done, exp_error, 1'b0}) begin
        errors++;
        $display("[TB] FAIL random%0d_status: got %b expected %b", it,
                 {done, error, loading}, {exp_done, exp_error, 1'b0});
      end
    end
  endtask

  task automatic test_max_length();
    logic [7:0] x;
    clear_writes();
    stim = '{8'h00, 8'h00, 8'h01, 8'h00};
    x = 8'h00;
    for (int i = 0; i < 4 * MAX_N; i++) begin
      stim.push_back(8'($urandom_range(255, 0)));
      x = x ^ stim[stim.size() - 1];
    end
`ifdef LOADER_CHECKSUM_EN
    stim.push_back(x);
`endif
    model_load();
    pulse_start();
    send_stim(0);
    repeat (3) @(negedge clk);
    checks++;
    if (wr_data.size() !== MAX_N) begin
      errors++;
      $display("[TB] FAIL maxlen_count: got %0d expected %0d", wr_data.size(), MAX_N);
    end else begin
      checks++;
      if (wr_addr[MAX_N-1] !== 32'h3FC) begin
        errors++;
        $display("[TB] FAIL maxlen_last_addr: got %h expected 3fc", wr_addr[MAX_N-1]);
      end
      for (int i = 0; i < MAX_N; i++) begin
        checks++;
        if (wr_data[i] !== exp_data[i]) begin
          errors++;
          $display("[TB] FAIL maxlen_w%0d: got %h expected %h", i, wr_data[i], exp_data[i]);
        end
      end
    end
    checks++;
    if ({done, error} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL maxlen_done: got %b expected 10", {done, error});
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    clear_writes();
    stim = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0F};
    pulse_start();
    send_stim(1);
    repeat (2) @(negedge clk);
    checks++;
    if ({done, error} !== 2'b10 || wr_data.size() !== 1) begin
      errors++;
      $display("[TB] FAIL csum_good: got %b writes %0d expected 10 writes 1", {done, error}, wr_data.size());
    end
    clear_writes();
    stim = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0E};
    pulse_start();
    send_stim(1);
    repeat (2) @(negedge clk);
    checks++;
    if ({done, error} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL csum_bad: got %b expected 01", {done, error});
    end
    checks++;
    if (wr_data.size() !== 1 || wr_data[0] !== 32'h01020408) begin
      errors++;
      $display("[TB] FAIL csum_bad_write: got %0d writes expected 1 write 01020408", wr_data.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_zero_length();
    test_oversize();
    test_back_to_back();
    test_reset_mid_word();
    test_restart();
    test_random();
    test_max_length();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
